// File: rtl/chunked_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit slice is reused across the operand,
// with the carry held in a register between slices. Valid/ready on both sides.
module chunked_adder_ctrl #(
  parameter int WIDTH = 100,
  parameter int CHUNK = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_chunk_check
    $error("chunked_adder_ctrl: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   slice_sum;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    a_slice   = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_slice   = b_q[int'(idx_q)*CHUNK +: CHUNK];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + (CHUNK+1)'(carry_q);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        carry_d = slice_sum[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_sum[CHUNK];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded before RUN reads them.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_adder_ctrl.sv
// Self-checking bench for chunked_adder_ctrl: directed scenarios plus a randomized
// producer/consumer run scored against a plain full-width addition model.
module tb_chunked_adder_ctrl;

  localparam int WIDTH  = 100;
  localparam int CHUNK  = 25;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int NOPS   = 1000;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  chunked_adder_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             c);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [127:0] r;
    int sel;
    sel = int'($urandom_range(0, 7));
    r   = {$urandom, $urandom, $urandom, $urandom};
    if (sel == 0) r = '1;
    else if (sel == 1) r = '0;
    return r[WIDTH-1:0];
  endfunction

  // Presents one operation, waits for the result, then pops it with a one-cycle out_ready.
  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xc, output logic [WIDTH-1:0] rs,
                        output logic rc, output int lat);
    int wait_n;
    wait_n = 0;
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    while (!in_ready && wait_n < 50) begin
      tick();
      wait_n++;
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    rs = sum;
    rc = cout;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b busy=%0b cout=%0b sum=%h, want 1 0 0 0 0",
               in_ready, out_valid, busy, cout, sum);
    end
  endtask

  task automatic test_full_ripple();
    logic [WIDTH-1:0] rs;
    logic rc;
    int lat;
    run_op('1, '0, 1'b1, rs, rc, lat);
    tests_run++;
    if (lat !== NCHUNK) begin
      tests_failed++;
      $display("FAIL ripple_latency: got %0d cycles, want %0d", lat, NCHUNK);
    end
    tests_run++;
    if (rs !== '0 || rc !== 1'b1) begin
      tests_failed++;
      $display("FAIL ripple_result: sum=%h cout=%0b, want sum=0 cout=1", rs, rc);
    end
    tests_run++;
    if (!in_ready || out_valid) begin
      tests_failed++;
      $display("FAIL ripple_release: in_ready=%0b out_valid=%0b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_chunk_boundary();
    logic [WIDTH-1:0] rs, xa, want;
    logic rc;
    int lat;
    xa   = (WIDTH'(1) << 25) - WIDTH'(1);
    want = WIDTH'(1) << 25;
    run_op(xa, WIDTH'(1), 1'b0, rs, rc, lat);
    tests_run++;
    if (rs !== want || rc !== 1'b0) begin
      tests_failed++;
      $display("FAIL chunk_boundary: sum=%h cout=%0b, want sum=%h cout=0", rs, rc, want);
    end
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] xa, xb, hs;
    logic [WIDTH:0] want;
    logic hc;
    int lat;
    xa = rand_word(); xb = rand_word();
    want = ref_add(xa, xb, 1'b1);
    a = xa; b = xb; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    tests_run++;
    if (lat !== NCHUNK || {cout, sum} !== want) begin
      tests_failed++;
      $display("FAIL hold_first: lat=%0d result=%h, want lat=%0d result=%h", lat, {cout, sum}, NCHUNK, want);
    end
    hs = sum; hc = cout;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== hs || cout !== hc) begin
        tests_failed++;
        $display("FAIL hold_stable[%0d]: out_valid=%0b in_ready=%0b result=%h, want 1 0 %h",
                 i, out_valid, in_ready, {cout, sum}, {hc, hs});
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_release: out_valid=%0b in_ready=%0b, want 0 1", out_valid, in_ready);
    end
    tests_run++;
    if (sum !== hs || cout !== hc) begin
      tests_failed++;
      $display("FAIL idle_retain: result=%h, want %h", {cout, sum}, {hc, hs});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH-1:0] rs;
    logic rc;
    int lat;
    bit seen;
    a = '1; b = '1; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_reset: in_ready=%0b out_valid=%0b busy=%0b sum=%h cout=%0b, want 1 0 0 0 0",
               in_ready, out_valid, busy, sum, cout);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL midrun_abandon: out_valid=1 seen after reset, want 0");
    end
    run_op(WIDTH'(5), WIDTH'(7), 1'b0, rs, rc, lat);
    tests_run++;
    if (rs !== WIDTH'(12) || rc !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_op: sum=%0d cout=%0b, want 12 0", rs, rc);
    end
  endtask

  task automatic test_random();
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] e;
    logic [WIDTH-1:0] s_smp;
    logic c_smp, acc, dlv;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (recv < NOPS && cyc < 60000) begin
      if (!in_valid && sent < NOPS && $urandom_range(0, 2) == 0) begin
        a = rand_word(); b = rand_word(); cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc   = in_valid && in_ready;
      dlv   = out_valid && out_ready;
      s_smp = sum;
      c_smp = cout;
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back(ref_add(a, b, cin));
        sent++;
        in_valid = 1'b0;
      end
      if (dlv) begin
        recv++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL random_extra: result %h with nothing outstanding", {c_smp, s_smp});
        end else begin
          e = exp_q.pop_front();
          if ({c_smp, s_smp} !== e) begin
            tests_failed++;
            $display("FAIL random_result[%0d]: got %h, want %h", recv - 1, {c_smp, s_smp}, e);
          end
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (recv !== NOPS || sent !== NOPS || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL random_count: sent=%0d received=%0d pending=%0d cycles=%0d, want %0d %0d 0",
               sent, recv, exp_q.size(), cyc, NOPS, NOPS);
    end
  endtask

  initial begin
    test_reset();
    test_full_ripple();
    test_chunk_boundary();
    test_hold();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
